// File: rtl/dmem_access_unit.sv
// MEM-stage data memory access unit: req/ack bus handshake, byte lanes,
// load extension, pipeline stall and timeout abort.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_be,
    input  logic [63:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] tmo_cnt;
    logic [1:0]  size_q;
    logic        zext_q;
    logic [2:0]  off_q;

    logic        access;
    logic        illegal;
    logic        unaligned;
    logic        legal;
    logic        tmo_hit;
    logic [7:0]  be_nxt;
    logic [63:0] shifted;
    logic [63:0] load_ext;

    assign access  = mem_read | mem_write;
    // A simultaneous read+write request is handled as a store.
    assign illegal = mem_write ? funct3[2] : (funct3 == 3'b111);
    assign legal   = access & ~illegal & ~unaligned;
    assign tmo_hit = (state == BUSY) & ~bus_ack & (TIMEOUT != 0)
                   & (tmo_cnt == TIMEOUT - 1);

    always_comb begin
        unaligned = 1'b0;
        be_nxt    = 8'hFF;
        unique case (funct3[1:0])
            2'b00: begin
                unaligned = 1'b0;
                be_nxt    = 8'h01 << addr[2:0];
            end
            2'b01: begin
                unaligned = addr[0];
                be_nxt    = 8'h03 << addr[2:0];
            end
            2'b10: begin
                unaligned = |addr[1:0];
                be_nxt    = 8'h0F << addr[2:0];
            end
            default: begin
                unaligned = |addr[2:0];
                be_nxt    = 8'hFF;
            end
        endcase
    end

    always_comb begin
        shifted  = bus_rdata >> {off_q, 3'b000};
        load_ext = shifted;
        unique case (size_q)
            2'b00: load_ext = zext_q ? {56'd0, shifted[7:0]}
                                     : {{56{shifted[7]}}, shifted[7:0]};
            2'b01: load_ext = zext_q ? {48'd0, shifted[15:0]}
                                     : {{48{shifted[15]}}, shifted[15:0]};
            2'b10: load_ext = zext_q ? {32'd0, shifted[31:0]}
                                     : {{32{shifted[31]}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (legal) state_nxt = BUSY;
            BUSY:    if (bus_ack || tmo_hit) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        misaligned = 1'b0;
        unique case (state)
            IDLE: begin
                stall      = legal;
                misaligned = access & ~legal;
            end
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata     <= '0;
            bus_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            tmo_cnt   <= '0;
            size_q    <= '0;
            zext_q    <= 1'b0;
            off_q     <= '0;
        end else begin
            bus_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (legal) begin
                        size_q    <= funct3[1:0];
                        zext_q    <= funct3[2];
                        off_q     <= addr[2:0];
                        bus_we    <= mem_write;
                        bus_addr  <= {addr[63:3], 3'b000};
                        bus_be    <= be_nxt;
                        bus_wdata <= wdata << {addr[2:0], 3'b000};
                        bus_req   <= 1'b1;
                        tmo_cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) rdata <= load_ext;
                    end else if (tmo_hit) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
